// File: rtl/vector_processor_defs.sv
// Shared definitions for the vector instruction intake path: opcode
// constants, the configuration func3 code, the issue FSM state type and
// small decode helpers used by the queue.
package vector_processor_defs;

  localparam logic [6:0] V_ARITH = 7'h57;
  localparam logic [6:0] V_LOAD  = 7'h07;
  localparam logic [6:0] V_STORE = 7'h27;
  localparam logic [2:0] CONF    = 3'b111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } issue_state_e;

  // True for any opcode the vector unit executes.
  function automatic logic is_vec_opcode(input logic [6:0] opcode);
    logic hit;
    case (opcode)
      V_ARITH: hit = 1'b1;
      V_LOAD:  hit = 1'b1;
      V_STORE: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // vset* instructions live in the arithmetic opcode space with func3=111.
  function automatic logic is_config(input logic [6:0] opcode, input logic [2:0] func3);
    return (opcode == V_ARITH) && (func3 == CONF);
  endfunction

endpackage

// File: rtl/vec_inst_fifo.sv
// Synchronous FIFO holding {inst, rs1, rs2} entries for the vector
// instruction queue. Push/pop are ignored when full/empty respectively;
// flush empties the FIFO in one cycle.
module vec_inst_fifo
  import vector_processor_defs::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Entry storage: a write lands at the clock edge, readable the cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vector_inst_queue.sv
// Vector instruction intake: filters non-vector opcodes, buffers accepted
// instructions with their scalar operands, and issues them one at a time
// to the controller. Configuration instructions retire without waiting
// for vec_done; everything else is held until the datapath completes.
module vector_inst_queue
  import vector_processor_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inst_valid,
  input  logic [XLEN-1:0]            vec_inst,
  input  logic [XLEN-1:0]            rs1_data,
  input  logic [XLEN-1:0]            rs2_data,
  output logic                       inst_ready,
  output logic                       illegal_inst,
  output logic                       issue_valid,
  output logic [XLEN-1:0]            issue_inst,
  output logic [XLEN-1:0]            issue_rs1,
  output logic [XLEN-1:0]            issue_rs2,
  input  logic                       vec_done,
  input  logic                       flush,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int EW = 3 * XLEN;
  localparam int CW = $clog2(DEPTH) + 1;

  issue_state_e     state_r;
  issue_state_e     state_s;
  logic             full_s;
  logic             empty_s;
  logic [CW-1:0]    count_s;
  logic [EW-1:0]    head_s;
  logic             opcode_ok_s;
  logic             push_s;
  logic             pop_s;
  logic             capture_s;
  logic             head_is_conf_s;
  logic             issue_valid_r;
  logic             illegal_inst_r;
  logic [XLEN-1:0]  issue_inst_r;
  logic [XLEN-1:0]  issue_rs1_r;
  logic [XLEN-1:0]  issue_rs2_r;

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign inst_ready     = !full_s;
  assign opcode_ok_s    = is_vec_opcode(vec_inst[6:0]);
  assign push_s         = inst_valid && inst_ready && opcode_ok_s && !flush;
  assign head_is_conf_s = is_config(issue_inst_r[6:0], issue_inst_r[14:12]);

  vec_inst_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push_s),
    .din   ({vec_inst, rs1_data, rs2_data}),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Issue FSM next-state logic; pop only retires an instruction already issued.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            capture_s = 1'b1;
            state_s   = ISSUE;
          end else begin
            state_s = IDLE;
          end
        end
        ISSUE: begin
          if (head_is_conf_s) begin
            pop_s   = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (vec_done) begin
            pop_s   = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = WAIT_DONE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Issue registers: head captured on leaving IDLE, held until next issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid_r <= 1'b0;
      issue_inst_r  <= {XLEN{1'b0}};
      issue_rs1_r   <= {XLEN{1'b0}};
      issue_rs2_r   <= {XLEN{1'b0}};
    end else begin
      issue_valid_r <= capture_s;
      if (capture_s) begin
        issue_inst_r <= head_s[EW-1 -: XLEN];
        issue_rs1_r  <= head_s[2*XLEN-1 -: XLEN];
        issue_rs2_r  <= head_s[XLEN-1:0];
      end
    end
  end

  // One-cycle illegal pulse for an offered non-vector opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_inst_r <= 1'b0;
    end else begin
      illegal_inst_r <= inst_valid && inst_ready && !opcode_ok_s && !flush;
    end
  end

  assign issue_valid  = issue_valid_r;
  assign illegal_inst = illegal_inst_r;
  assign issue_inst   = issue_inst_r;
  assign issue_rs1    = issue_rs1_r;
  assign issue_rs2    = issue_rs2_r;
  assign count        = count_s;
  assign busy         = (count_s != {CW{1'b0}}) || (state_r != IDLE);

endmodule

// File: tb/tb_vector_inst_queue.sv
// Directed testbench for vector_inst_queue with hand-computed expectations.
module tb_vector_inst_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] VSET = 32'h0C0572D7;
  localparam logic [31:0] LD   = 32'h02056407;
  localparam logic [31:0] ADD  = 32'h00B50533;

  logic            clk = 1'b0;
  logic            reset;
  logic            inst_valid;
  logic [XLEN-1:0] vec_inst;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            inst_ready;
  logic            illegal_inst;
  logic            issue_valid;
  logic [XLEN-1:0] issue_inst;
  logic [XLEN-1:0] issue_rs1;
  logic [XLEN-1:0] issue_rs2;
  logic            vec_done;
  logic            flush;
  logic            busy;
  logic [2:0]      count;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_inst [10];
  logic [31:0] exp_rs1  [10];
  int          n_issued;

  vector_inst_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_valid   (inst_valid),
    .vec_inst     (vec_inst),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .inst_ready   (inst_ready),
    .illegal_inst (illegal_inst),
    .issue_valid  (issue_valid),
    .issue_inst   (issue_inst),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .vec_done     (vec_done),
    .flush        (flush),
    .busy         (busy),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    inst_valid = 1'b0;
    vec_inst   = '0;
    rs1_data   = '0;
    rs2_data   = '0;
    vec_done   = 1'b0;
    flush      = 1'b0;
    repeat (3) step();
    check_vec("rst_count", 64'(count), 64'd0);
    check_vec("rst_ready", 64'(inst_ready), 64'd1);
    check_vec("rst_busy", 64'(busy), 64'd0);
    check_vec("rst_issue_valid", 64'(issue_valid), 64'd0);
    check_vec("rst_illegal", 64'(illegal_inst), 64'd0);
    check_vec("rst_issue_inst", 64'(issue_inst), 64'd0);
    reset = 1'b0;
    step();

    // Test 1: single vsetvli retires without vec_done
    inst_valid = 1'b1; vec_inst = VSET; rs1_data = 32'd8; rs2_data = 32'd0;
    step();
    inst_valid = 1'b0;
    check_vec("t1_count_after_push", 64'(count), 64'd1);
    check_vec("t1_no_early_issue", 64'(issue_valid), 64'd0);
    step();
    check_vec("t1_issue_valid", 64'(issue_valid), 64'd1);
    check_vec("t1_issue_inst", 64'(issue_inst), 64'(VSET));
    check_vec("t1_issue_rs1", 64'(issue_rs1), 64'd8);
    step();
    check_vec("t1_issue_pulse_end", 64'(issue_valid), 64'd0);
    check_vec("t1_count_zero", 64'(count), 64'd0);
    check_vec("t1_idle", 64'(busy), 64'd0);

    // Test 2: load waits for vec_done
    inst_valid = 1'b1; vec_inst = LD; rs1_data = 32'h1000; rs2_data = 32'h4;
    step();
    inst_valid = 1'b0;
    step();
    check_vec("t2_issue_valid", 64'(issue_valid), 64'd1);
    check_vec("t2_issue_inst", 64'(issue_inst), 64'(LD));
    check_vec("t2_issue_rs2", 64'(issue_rs2), 64'h4);
    step();
    check_vec("t2_pulse_end", 64'(issue_valid), 64'd0);
    repeat (3) step();
    check_vec("t2_busy_wait", 64'(busy), 64'd1);
    check_vec("t2_count_held", 64'(count), 64'd1);
    vec_done = 1'b1;
    step();
    vec_done = 1'b0;
    check_vec("t2_busy_clear", 64'(busy), 64'd0);
    check_vec("t2_count_zero", 64'(count), 64'd0);

    // Test 3: fill to DEPTH, back-pressure, then release one slot
    for (int i = 0; i < 4; i++) begin
      inst_valid = 1'b1; vec_inst = LD; rs1_data = 32'(i); rs2_data = 32'd0;
      step();
    end
    inst_valid = 1'b0;
    check_vec("t3_count_full", 64'(count), 64'd4);
    check_vec("t3_ready_low", 64'(inst_ready), 64'd0);
    inst_valid = 1'b1; rs1_data = 32'd99;
    step();
    inst_valid = 1'b0;
    check_vec("t3_fifth_rejected", 64'(count), 64'd4);
    vec_done = 1'b1;
    step();
    vec_done = 1'b0;
    check_vec("t3_count_after_done", 64'(count), 64'd3);
    check_vec("t3_ready_high", 64'(inst_ready), 64'd1);

    // Test 5: flush with head in WAIT_DONE, plus offer and vec_done
    step();
    check_vec("t5_issue_rs1_second", 64'(issue_rs1), 64'd1);
    step();
    check_vec("t5_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1; inst_valid = 1'b1; vec_inst = LD; vec_done = 1'b1;
    step();
    flush = 1'b0; inst_valid = 1'b0; vec_done = 1'b0;
    check_vec("t5_count_zero", 64'(count), 64'd0);
    check_vec("t5_busy_zero", 64'(busy), 64'd0);
    check_vec("t5_no_issue", 64'(issue_valid), 64'd0);
    check_vec("t5_ready", 64'(inst_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_vec("t5_quiet_issue", 64'(issue_valid), 64'd0);
      check_vec("t5_quiet_count", 64'(count), 64'd0);
    end

    // Test 4: non-vector opcode is flagged and dropped
    inst_valid = 1'b1; vec_inst = ADD; rs1_data = 32'd5;
    step();
    inst_valid = 1'b0;
    check_vec("t4_illegal_pulse", 64'(illegal_inst), 64'd1);
    check_vec("t4_count", 64'(count), 64'd0);
    step();
    check_vec("t4_illegal_end", 64'(illegal_inst), 64'd0);
    check_vec("t4_no_issue", 64'(issue_valid), 64'd0);
    check_vec("t4_busy", 64'(busy), 64'd0);

    // Test 6: stream of 10 vset* instructions through a wrapping FIFO
    for (int i = 0; i < 10; i++) begin
      exp_inst[i] = VSET + (32'(i) << 20);
      exp_rs1[i]  = 32'h100 + 32'(i);
    end
    n_issued = 0;
    fork
      begin : driver
        for (int i = 0; i < 10; i++) begin
          logic acc;
          int   wait_cnt;
          acc = 1'b0;
          wait_cnt = 0;
          inst_valid = 1'b1; vec_inst = exp_inst[i]; rs1_data = exp_rs1[i]; rs2_data = 32'(i);
          while (!acc && wait_cnt < 20) begin
            acc = inst_ready;
            step();
            wait_cnt++;
          end
          if (!acc) begin
            check_vec("t6_push_timeout", 64'(i), 64'hFFFF);
          end
        end
        inst_valid = 1'b0;
      end
      begin : monitor
        for (int c = 0; c < 60; c++) begin
          step();
          if (issue_valid) begin
            if (n_issued < 10) begin
              check_vec("t6_issue_inst", 64'(issue_inst), 64'(exp_inst[n_issued]));
              check_vec("t6_issue_rs1", 64'(issue_rs1), 64'(exp_rs1[n_issued]));
            end
            n_issued++;
          end
        end
      end
    join
    check_vec("t6_issue_count", 64'(n_issued), 64'd10);
    check_vec("t6_drained_count", 64'(count), 64'd0);
    check_vec("t6_drained_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
